// File: rtl/mem_rd_arb.sv
// Two-requester read arbiter for one shared memory port. Returns are routed
// back to the requester through an in-order tag FIFO; a soft reset drains them.
module mem_rd_arb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              eng_rstn,
  input  logic              bm_rd_rq,
  input  logic [ADDR_W-1:0] bm_rd_addr,
  output logic              bm_rd_gnt,
  output logic [DATA_W-1:0] bm_rd_data,
  output logic              bm_rd_data_val,
  input  logic              ib_rd_rq,
  input  logic [ADDR_W-1:0] ib_rd_addr,
  output logic              ib_rd_gnt,
  output logic [DATA_W-1:0] ib_rd_data,
  output logic              ib_rd_data_val,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_data_val,
  output logic              busy,
  output logic              proto_err
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [MAX_OUT-1:0]  r_tag;
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [CW-1:0]       r_cnt, r_drain_cnt;
  logic [CW-1:0]       w_cnt_pop, w_cnt_nxt, w_drain_nxt;
  logic                r_last_ib;
  logic                w_pop, w_orphan, w_push, w_can_issue, w_clear;
  logic                r_bm_val, r_ib_val, r_proto_err;
  logic [DATA_W-1:0]   r_bm_data, r_ib_data;

  always_comb begin
    w_pop       = (r_state == RUN) && mem_rd_data_val && (r_cnt != '0);
    w_orphan    = (r_state == RUN) && mem_rd_data_val && (r_cnt == '0);
    w_cnt_pop   = r_cnt - {{(CW-1){1'b0}}, w_pop};
    // A return in this cycle frees a slot for a grant in the same cycle.
    w_can_issue = rstn && eng_rstn && (r_state == RUN) && (w_cnt_pop < MAX_CNT);
    bm_rd_gnt   = w_can_issue && bm_rd_rq && (!ib_rd_rq || r_last_ib);
    ib_rd_gnt   = w_can_issue && ib_rd_rq && (!bm_rd_rq || !r_last_ib);
    w_push      = bm_rd_gnt || ib_rd_gnt;
    mem_rd_req  = w_push;
    mem_rd_addr = bm_rd_gnt ? bm_rd_addr : (ib_rd_gnt ? ib_rd_addr : '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_drain_nxt = r_drain_cnt;
    w_cnt_nxt   = w_cnt_pop + {{(CW-1){1'b0}}, w_push};
    case (r_state)
      RUN: begin
        if (!eng_rstn) begin
          w_clear   = 1'b1;
          w_cnt_nxt = '0;
          if (w_cnt_pop != '0) begin
            w_state_nxt = DRAIN;
            w_drain_nxt = w_cnt_pop;
          end
        end
      end
      DRAIN: begin
        if (mem_rd_data_val) begin
          if (r_drain_cnt <= ONE) begin
            w_drain_nxt = '0;
            w_state_nxt = RUN;
          end else begin
            w_drain_nxt = r_drain_cnt - ONE;
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_tag       <= '0;
      r_last_ib   <= 1'b1;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_orphan) r_proto_err <= 1'b1;
      if (w_push) begin
        r_tag[r_wptr] <= ib_rd_gnt;
        r_last_ib     <= ib_rd_gnt;
      end
      if (w_clear) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Return path: one register stage, only the tagged requester's data updates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bm_val  <= 1'b0;
      r_ib_val  <= 1'b0;
      r_bm_data <= '0;
      r_ib_data <= '0;
    end else begin
      r_bm_val <= w_pop && !r_tag[r_rptr];
      r_ib_val <= w_pop &&  r_tag[r_rptr];
      if (w_pop && !r_tag[r_rptr]) r_bm_data <= mem_rd_data;
      if (w_pop &&  r_tag[r_rptr]) r_ib_data <= mem_rd_data;
    end
  end

  assign bm_rd_data_val = r_bm_val;
  assign ib_rd_data_val = r_ib_val;
  assign bm_rd_data     = r_bm_data;
  assign ib_rd_data     = r_ib_data;
  assign busy           = (r_cnt != '0) || (r_state == DRAIN);
  assign proto_err      = r_proto_err;

endmodule

// File: tb/tb_mem_rd_arb.sv
// Directed bench for mem_rd_arb: arbitration order, return routing, backpressure,
// soft-reset drain, orphan returns and asynchronous reset.
module tb_mem_rd_arb;

  logic        clk = 1'b0;
  logic        rstn, eng_rstn;
  logic        bm_rd_rq, ib_rd_rq;
  logic [7:0]  bm_rd_addr, ib_rd_addr;
  logic        bm_rd_gnt, ib_rd_gnt;
  logic [31:0] bm_rd_data, ib_rd_data;
  logic        bm_rd_data_val, ib_rd_data_val;
  logic        mem_rd_req;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_data_val;
  logic        busy, proto_err;

  int n_chk = 0;
  int n_bad = 0;
  int n_g;

  always #5 clk = ~clk;

  mem_rd_arb #(.ADDR_W(8), .DATA_W(32), .MAX_OUT(4)) dut (
    .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn),
    .bm_rd_rq(bm_rd_rq), .bm_rd_addr(bm_rd_addr), .bm_rd_gnt(bm_rd_gnt),
    .bm_rd_data(bm_rd_data), .bm_rd_data_val(bm_rd_data_val),
    .ib_rd_rq(ib_rd_rq), .ib_rd_addr(ib_rd_addr), .ib_rd_gnt(ib_rd_gnt),
    .ib_rd_data(ib_rd_data), .ib_rd_data_val(ib_rd_data_val),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_data_val(mem_rd_data_val),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    eng_rstn = 1'b1;
    bm_rd_rq = 1'b0; ib_rd_rq = 1'b0;
    bm_rd_addr = '0; ib_rd_addr = '0;
    mem_rd_data = '0; mem_rd_data_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn = 1'b0; eng_rstn = 1'b1;
    bm_rd_rq = 1'b0; ib_rd_rq = 1'b0;
    bm_rd_addr = '0; ib_rd_addr = '0;
    mem_rd_data = '0; mem_rd_data_val = 1'b0;

    // Reset state, with a request present that must not be granted.
    bm_rd_rq = 1'b1;
    #12;
    chk("rst_bm_gnt", bm_rd_gnt, 0);
    chk("rst_mem_req", mem_rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_bm_val", bm_rd_data_val, 0);
    chk("rst_ib_data", ib_rd_data, 0);

    // Single bm read, latency 3.
    do_reset();
    bm_rd_rq = 1'b1; bm_rd_addr = 8'h12; #1;
    chk("t1_gnt", bm_rd_gnt, 1);
    chk("t1_req", mem_rd_req, 1);
    chk("t1_addr", mem_rd_addr, 8'h12);
    chk("t1_ib_gnt", ib_rd_gnt, 0);
    tick(); bm_rd_rq = 1'b0; #1;
    chk("t1_busy", busy, 1);
    tick(); tick();
    mem_rd_data_val = 1'b1; mem_rd_data = 32'hCAFEF00D;
    tick(); mem_rd_data_val = 1'b0;
    chk("t1_bm_val", bm_rd_data_val, 1);
    chk("t1_bm_data", bm_rd_data, 32'hCAFEF00D);
    chk("t1_ib_val", ib_rd_data_val, 0);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_pulse", bm_rd_data_val, 0);

    // Both requesting: bm, ib, bm, ib; then returns route in that order.
    do_reset();
    bm_rd_rq = 1'b1; bm_rd_addr = 8'hA0;
    ib_rd_rq = 1'b1; ib_rd_addr = 8'hB0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_bm_gnt", bm_rd_gnt, (i % 2 == 0) ? 1 : 0);
      chk("rr_ib_gnt", ib_rd_gnt, (i % 2 == 1) ? 1 : 0);
      chk("rr_addr", mem_rd_addr, (i % 2 == 0) ? 8'hA0 : 8'hB0);
      tick();
    end
    chk("rr_full", mem_rd_req, 0);
    bm_rd_rq = 1'b0; ib_rd_rq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rd_data_val = 1'b1; mem_rd_data = 32'h100 + i;
      tick();
      chk("rr_bm_val", bm_rd_data_val, (i % 2 == 0) ? 1 : 0);
      chk("rr_ib_val", ib_rd_data_val, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) chk("rr_bm_data", bm_rd_data, 32'h100 + i);
      else            chk("rr_ib_data", ib_rd_data, 32'h100 + i);
      if (i == 2)     chk("rr_ib_hold", ib_rd_data, 32'h101);
    end
    mem_rd_data_val = 1'b0;
    chk("rr_idle", busy, 0);

    // No returns: exactly MAX_OUT grants, then stall until a return.
    do_reset();
    bm_rd_rq = 1'b1; bm_rd_addr = 8'h33; #1;
    n_g = 0;
    for (int c = 0; c < 6; c++) begin
      n_g += bm_rd_gnt;
      tick();
    end
    chk("bp_grants", n_g, 4);
    chk("bp_gnt0", bm_rd_gnt, 0);
    chk("bp_busy", busy, 1);
    mem_rd_data_val = 1'b1; mem_rd_data = 32'h55; #1;
    chk("bp_regrant", bm_rd_gnt, 1);
    tick(); mem_rd_data_val = 1'b0; #1;
    chk("bp_full_again", bm_rd_gnt, 0);

    // Soft reset with 3 outstanding: drain, then resume.
    do_reset();
    bm_rd_rq = 1'b1; bm_rd_addr = 8'h21;
    tick(); tick(); tick();
    bm_rd_rq = 1'b0; eng_rstn = 1'b0;
    tick(); eng_rstn = 1'b1;
    bm_rd_rq = 1'b1; #1;
    chk("dr_busy", busy, 1);
    chk("dr_nogrant", bm_rd_gnt, 0);
    for (int i = 0; i < 3; i++) begin
      mem_rd_data_val = 1'b1; mem_rd_data = 32'hD0 + i; #1;
      chk("dr_gnt_blocked", bm_rd_gnt, 0);
      tick(); mem_rd_data_val = 1'b0;
      chk("dr_bm_val", bm_rd_data_val, 0);
      chk("dr_perr", proto_err, 0);
    end
    #1;
    chk("dr_resume_gnt", bm_rd_gnt, 1);
    tick(); bm_rd_rq = 1'b0;

    // Orphan return sets a sticky error that only rstn clears.
    do_reset();
    mem_rd_data_val = 1'b1; mem_rd_data = 32'hBAD;
    tick(); mem_rd_data_val = 1'b0;
    chk("oe_perr", proto_err, 1);
    chk("oe_bm_val", bm_rd_data_val, 0);
    chk("oe_ib_val", ib_rd_data_val, 0);
    eng_rstn = 1'b0; tick(); eng_rstn = 1'b1; tick();
    chk("oe_sticky", proto_err, 1);
    @(negedge clk); rstn = 1'b0; #1;
    chk("oe_cleared", proto_err, 0);

    // Asynchronous reset in the middle of traffic.
    do_reset();
    bm_rd_rq = 1'b1; bm_rd_addr = 8'h44;
    tick(); tick();
    mem_rd_data_val = 1'b1; mem_rd_data = 32'hDEAD;
    tick(); mem_rd_data_val = 1'b0;
    chk("ar_pre_val", bm_rd_data_val, 1);
    chk("ar_pre_gnt", bm_rd_gnt, 1);
    #2 rstn = 1'b0; #1;
    chk("ar_gnt", bm_rd_gnt, 0);
    chk("ar_req", mem_rd_req, 0);
    chk("ar_addr", mem_rd_addr, 0);
    chk("ar_val", bm_rd_data_val, 0);
    chk("ar_data", bm_rd_data, 0);
    chk("ar_busy", busy, 0);
    bm_rd_rq = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
